// File: rtl/seq_adder_nbit.sv
// Multi-cycle ripple adder/subtractor: CHUNK bits per clock, LSB chunk first, carry held in a register.
// Optional SEQ_ADDER_ACCUM_EN adds an acc input that substitutes the previous result for operand a.
module seq_adder_nbit #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
`ifdef SEQ_ADDER_ACCUM_EN
   input  logic             acc,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [IW-1:0]    idx;
   logic             carry;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] a_sel;
   logic [31:0]      base;
   logic [CHUNK-1:0] ach;
   logic [CHUNK-1:0] bch;
   logic [CHUNK:0]   csum;
   logic             msb_ovf;

   function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic c);
      return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
   endfunction

`ifdef SEQ_ADDER_ACCUM_EN
   assign a_sel = acc ? s : a;
`else
   assign a_sel = a;
`endif

   always_comb begin
      base = 32'(idx) * 32'(CHUNK);
      ach  = opa[base +: CHUNK];
      bch  = opb[base +: CHUNK];
      csum = chunk_add(ach, bch, carry);
      // Carry into the MSB is recovered from the MSB's own sum bit, so this holds for any CHUNK
      msb_ovf = ach[CHUNK-1] ^ bch[CHUNK-1] ^ csum[CHUNK-1] ^ csum[CHUNK];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         carry     <= 1'b0;
         opa       <= '0;
         opb       <= '0;
         s         <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  opa      <= a_sel;
                  opb      <= sub ? ~b : b;
                  carry    <= sub | cin;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               s[base +: CHUNK] <= csum[CHUNK-1:0];
               carry            <= csum[CHUNK];
               if (idx == LAST) begin
                  idx       <= '0;
                  cout      <= csum[CHUNK];
                  ovf       <= msb_ovf;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_adder_nbit.sv
// Bench for seq_adder_nbit: directed vector table, randomized ops against an arithmetic model,
// back-pressure and asynchronous-reset sequences, plus the accumulate sequence when SEQ_ADDER_ACCUM_EN is set.
module tb_seq_adder_nbit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] s;
   logic        cout;
   logic        ovf;

   int nvec  = 0;
   int nfail = 0;

   always #5 clk = ~clk;

`ifdef SEQ_ADDER_ACCUM_EN
   logic       acc;
   logic       in_valid2, in_ready2, out_valid2, out_ready2, cout2, ovf2, acc2;
   logic [7:0] a2, b2, s2;

   seq_adder_nbit dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .acc(acc),
      .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
   );

   seq_adder_nbit #(.WIDTH(8), .CHUNK(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
      .a(a2), .b(b2), .cin(1'b0), .sub(1'b0), .acc(acc2),
      .out_valid(out_valid2), .out_ready(out_ready2), .s(s2), .cout(cout2), .ovf(ovf2)
   );
`else
   seq_adder_nbit dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
   );
`endif

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] s;
      logic        cout;
      logic        ovf;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic, signed range test for overflow, x>=y for no-borrow
   function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                         input logic c, input logic sb);
      int          sx, sy, r;
      logic [15:0] rs;
      logic        rc;
      sx = int'($signed(x));
      sy = int'($signed(y));
      if (sb) begin
         rs = x - y;
         rc = (x >= y);
         r  = sx - sy;
      end else begin
         rs = x + y + 16'(c);
         rc = (32'(x) + 32'(y) + 32'(c)) > 32'h0000_FFFF;
         r  = sx + sy + int'(c);
      end
      return {(r > 32767) || (r < -32768), rc, rs};
   endfunction

   task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic c, input logic sb,
                         output logic [15:0] rs, output logic rc, output logic ro, output int lat);
      int   n;
      logic rdy_seen;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("in_ready_before_accept", 32'(in_ready), 32'd1);
      a = x; b = y; cin = c; sub = sb; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      lat = 0;
      rdy_seen = 1'b0;
      while (!out_valid && lat < 20) begin
         rdy_seen |= in_ready;
         @(posedge clk); #1;
         lat++;
      end
      rdy_seen |= in_ready;
      check("in_ready_low_while_busy", 32'(rdy_seen), 32'd0);
      rs = s; rc = cout; ro = ovf;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      vec_t        tbl[6];
      logic [15:0] rs;
      logic        rc, ro;
      int          lat;
      logic [17:0] e;
      logic [15:0] x, y;
      logic        c, sb;
      logic        bad;

      tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
      tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      tbl[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      tbl[5] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
`ifdef SEQ_ADDER_ACCUM_EN
      acc = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0; acc2 = 1'b0; a2 = '0; b2 = '0;
`endif
      #12;
      check("reset_state", {15'd0, in_ready, out_valid, cout, ovf, s}, {15'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, rs, rc, ro, lat);
         check($sformatf("vec%0d_s", i), 32'(rs), 32'(tbl[i].s));
         check($sformatf("vec%0d_cout_ovf", i), {30'd0, rc, ro}, {30'd0, tbl[i].cout, tbl[i].ovf});
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      end

      for (int i = 0; i < 40; i++) begin
         x = 16'($urandom); y = 16'($urandom); c = 1'($urandom); sb = 1'($urandom);
         if (i < 4) x = (i[0]) ? 16'h8000 : 16'h7FFF;
         e = model(x, y, c, sb);
         run_op(x, y, c, sb, rs, rc, ro, lat);
         check($sformatf("rand%0d_result", i), {14'd0, ro, rc, rs}, {14'd0, e});
         check($sformatf("rand%0d_latency", i), 32'(lat), 32'd4);
      end

      // Back-pressure: in_valid held high with different operands the whole time
      e = model(16'h0F0F, 16'h0101, 1'b0, 1'b0);
      a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      a = 16'h2222; b = 16'h1111;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("bp_first_latency", 32'(lat), 32'd4);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp_hold%0d", k), {12'd0, out_valid, in_ready, ovf, cout, s},
               {12'd0, 1'b1, 1'b0, e});
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_release_ready", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      e = model(16'h2222, 16'h1111, 1'b0, 1'b0);
      check("bp_second_latency", 32'(lat), 32'd4);
      check("bp_second_result", {14'd0, ovf, cout, s}, {14'd0, e});
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Asynchronous reset while chunk index 2 is being processed
      a = 16'h5555; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 rst = 1'b1;
      #1;
      check("midrun_reset", {11'd0, in_ready, out_valid, cout, ovf, s}, {11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
      #1 rst = 1'b0;
      bad = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         bad |= out_valid | ~in_ready;
      end
      check("no_valid_after_reset", 32'(bad), 32'd0);
      run_op(16'h0001, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
      check("post_reset_op", {14'd0, ro, rc, rs}, {14'd0, 1'b0, 1'b0, 16'h0002});

`ifdef SEQ_ADDER_ACCUM_EN
      begin
         logic [7:0] bv[3];
         logic [7:0] ev[3];
         logic [8:0] prev;
         bv[0] = 8'h05; bv[1] = 8'h03; bv[2] = 8'hFB;
         ev[0] = 8'h05; ev[1] = 8'h08; ev[2] = 8'h03;
         prev = '0;
         for (int i = 0; i < 3; i++) begin
            a2 = 8'($urandom); b2 = bv[i]; acc2 = 1'b1; in_valid2 = 1'b1;
            @(posedge clk); #1;
            in_valid2 = 1'b0;
            lat = 0;
            while (!out_valid2 && lat < 20) begin
               @(posedge clk); #1;
               lat++;
            end
            prev = {1'b0, prev[7:0]} + {1'b0, bv[i]};
            check($sformatf("acc%0d_latency", i), 32'(lat), 32'd4);
            check($sformatf("acc%0d_s", i), 32'(s2), 32'(ev[i]));
            check($sformatf("acc%0d_model", i), 32'(s2), 32'(prev[7:0]));
            if (i == 2) check("acc_last_flags", {30'd0, cout2, ovf2}, {30'd0, 1'b1, 1'b0});
            out_ready2 = 1'b1;
            @(posedge clk); #1;
            out_ready2 = 1'b0;
         end
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
